sseg_ctrl_mmio: RTL and testbench

//  Slot-mapped, parametrised seven-segment display controller: N_DIGITS hex digits,
//  per-digit decimal point, blank and blink masks, PWM brightness, status readback.

---
 rtl/sseg_pkg.sv | 44 ++++
 rtl/sseg_scan.sv | 74 +++++++
 rtl/sseg_ctrl_mmio.sv | 98 +++++++++
 tb/tb_sseg_ctrl_mmio.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment controller: register map, CTRL layout
// and the hex-to-segment decoder.
package sseg_pkg;

    localparam logic [4:0] ADDR_DATA_LO = 5'd0;
    localparam logic [4:0] ADDR_DATA_HI = 5'd1;
    localparam logic [4:0] ADDR_DP      = 5'd2;
    localparam logic [4:0] ADDR_BLANK   = 5'd3;
    localparam logic [4:0] ADDR_BLINK   = 5'd4;
    localparam logic [4:0] ADDR_CTRL    = 5'd5;
    localparam logic [4:0] ADDR_STATUS  = 5'd6;

    localparam int         CTRL_EN_BIT  = 8;
    localparam int         CTRL_DUTY_W  = 8;
    localparam logic [8:0] CTRL_RESET   = 9'h1FF;

    // Digit index is sized for the largest supported display (16 digits).
    localparam int         IDX_W        = 4;

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_scan.sv
// Digit scan engine: slot and blink counters, current digit index, PWM compare
// and the registered anode/segment drivers.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_W   = 18,
    parameter int BLINK_W  = 26
)(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          duty_i,
    input  logic                enable_i,
    input  logic [3:0]          nibble_i,
    input  logic                dp_i,
    input  logic                blank_i,
    input  logic                blink_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                phase_o,
    output logic [N_DIGITS-1:0] an_o,
    output logic [7:0]          sseg_o
);

    logic [SCAN_W-1:0]   slot_q;
    logic [BLINK_W-1:0]  blink_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          sseg_q, sseg_d;
    logic [7:0]          pwm_top;
    logic [15:0]         onehot;
    logic                pwm_on, lit;

    // The slot counter's top byte is the PWM ramp, so brightness resolution is
    // independent of SCAN_W.
    assign pwm_top = slot_q[SCAN_W-1 -: 8];
    assign pwm_on  = (duty_i == 8'hFF) || (pwm_top < duty_i);
    assign phase_o = blink_q[BLINK_W-1];
    assign lit     = enable_i & pwm_on & ~blank_i & ~(blink_i & phase_o);
    assign onehot  = 16'd1 << idx_q;

    always_comb begin
        idx_d = idx_q;
        if (&slot_q) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        an_d   = '1;
        sseg_d = 8'hFF;
        if (lit) begin
            an_d   = ~onehot[N_DIGITS-1:0];
            sseg_d = {~dp_i, seg7(nibble_i)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q  <= '0;
            blink_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            sseg_q  <= 8'hFF;
        end else begin
            slot_q  <= slot_q + SCAN_W'(1);
            blink_q <= blink_q + BLINK_W'(1);
            idx_q   <= idx_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

    assign idx_o  = idx_q;
    assign an_o   = an_q;
    assign sseg_o = sseg_q;

endmodule

// File: rtl/sseg_ctrl_mmio.sv
// MMIO seven-segment display controller: register file, read mux and per-digit
// selection of data/mask bits feeding the scan engine.
module sseg_ctrl_mmio
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_W   = 18,
    parameter int BLINK_W  = 26
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [4:0]          addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          sseg
);

    logic [31:0]         data_lo_q, data_hi_q;
    logic [N_DIGITS-1:0] dp_q, blank_q, blink_q;
    logic [8:0]          ctrl_q;
    logic [IDX_W-1:0]    idx;
    logic                phase;
    logic [63:0]         digits;
    logic [15:0]         dp_w, blank_w, blink_w;
    logic [3:0]          nibble;
    logic                wr_en;
    logic                unused_read;

    // Reads have no side effects, so the strobe carries no information here.
    assign unused_read = read;
    assign wr_en       = cs & write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_lo_q <= '0;
            data_hi_q <= '0;
            dp_q      <= '0;
            blank_q   <= '0;
            blink_q   <= '0;
            ctrl_q    <= CTRL_RESET;
        end else if (wr_en) begin
            case (addr)
                ADDR_DATA_LO: data_lo_q <= wr_data;
                ADDR_DATA_HI: if (N_DIGITS > 8) data_hi_q <= wr_data;
                ADDR_DP:      dp_q      <= wr_data[N_DIGITS-1:0];
                ADDR_BLANK:   blank_q   <= wr_data[N_DIGITS-1:0];
                ADDR_BLINK:   blink_q   <= wr_data[N_DIGITS-1:0];
                ADDR_CTRL:    ctrl_q    <= wr_data[8:0];
                default: ;
            endcase
        end
    end

    // Widen masks to 16 bits so the 4-bit digit index selects without range issues.
    assign digits  = {data_hi_q, data_lo_q};
    assign dp_w    = 16'(dp_q);
    assign blank_w = 16'(blank_q);
    assign blink_w = 16'(blink_q);
    assign nibble  = digits[{idx, 2'b00} +: 4];

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA_LO: rd_data = data_lo_q;
            ADDR_DATA_HI: rd_data = data_hi_q;
            ADDR_DP:      rd_data = 32'(dp_q);
            ADDR_BLANK:   rd_data = 32'(blank_q);
            ADDR_BLINK:   rd_data = 32'(blink_q);
            ADDR_CTRL:    rd_data = 32'(ctrl_q);
            ADDR_STATUS:  rd_data = {27'd0, phase, idx};
            default: ;
        endcase
    end

    sseg_scan #(
        .N_DIGITS(N_DIGITS),
        .SCAN_W  (SCAN_W),
        .BLINK_W (BLINK_W)
    ) u_scan (
        .clk_i   (clk),
        .rst_i   (reset),
        .duty_i  (ctrl_q[CTRL_DUTY_W-1:0]),
        .enable_i(ctrl_q[CTRL_EN_BIT]),
        .nibble_i(nibble),
        .dp_i    (dp_w[idx]),
        .blank_i (blank_w[idx]),
        .blink_i (blink_w[idx]),
        .idx_o   (idx),
        .phase_o (phase),
        .an_o    (an),
        .sseg_o  (sseg)
    );

endmodule

// File: tb/tb_sseg_ctrl_mmio.sv
// Randomized bench for sseg_ctrl_mmio: an 8-digit and a 12-digit instance share one
// bus and are checked every clock against an arithmetic model of the display.
module tb_sseg_ctrl_mmio;

    localparam int SW = 8;
    localparam int BW = 10;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd8, rd12;
    logic [7:0]  an8, ss8, ss12;
    logic [11:0] an12;

    int checks = 0;
    int failures = 0;
    int k = 0;                   // clock edges since reset release
    logic [31:0] mr [2][6];      // model register contents per instance

    always #5 clk = ~clk;

    sseg_ctrl_mmio #(.N_DIGITS(8), .SCAN_W(SW), .BLINK_W(BW)) dut8 (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
        .wr_data(wr_data), .rd_data(rd8), .an(an8), .sseg(ss8));

    sseg_ctrl_mmio #(.N_DIGITS(12), .SCAN_W(SW), .BLINK_W(BW)) dut12 (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
        .wr_data(wr_data), .rd_data(rd12), .an(an12), .sseg(ss12));

    function automatic int nd_of(input int u);
        return (u == 0) ? 8 : 12;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 6; r++) mr[u][r] = '0;
            mr[u][5] = 32'h1FF;
        end
        k = 0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] m;
        for (int u = 0; u < 2; u++) begin
            m = (32'd1 << nd_of(u)) - 32'd1;
            case (int'(a))
                0: mr[u][0] = d;
                1: if (nd_of(u) > 8) mr[u][1] = d;
                2, 3, 4: mr[u][int'(a)] = d & m;
                5: mr[u][5] = {23'd0, d[8:0]};
                default: ;
            endcase
        end
    endtask

    // Display state after edge number kk+1, from the register contents before it.
    function automatic logic [23:0] exp_out(input int u, input int kk);
        int n, top, idx, ph;
        logic [7:0]  duty;
        logic [63:0] digits;
        logic [15:0] an_e;
        logic [7:0]  ss_e;
        logic        lit;
        n      = nd_of(u);
        top    = (kk % (1 << SW)) >> (SW - 8);
        idx    = (kk >> SW) % n;
        ph     = (kk >> (BW - 1)) & 1;
        duty   = mr[u][5][7:0];
        lit    = mr[u][5][8] && (duty == 8'hFF || top < int'(duty))
                 && !mr[u][3][idx] && !(mr[u][4][idx] && ph == 1);
        digits = {mr[u][1], mr[u][0]};
        an_e   = 16'hFFFF;
        ss_e   = 8'hFF;
        if (lit) begin
            an_e[idx] = 1'b0;
            ss_e = {~mr[u][2][idx], SEG_TAB[digits[idx*4 +: 4]]};
        end
        return {an_e, ss_e};
    endfunction

    function automatic logic [31:0] exp_rd(input int u, input logic [4:0] a, input int kk);
        if (int'(a) <= 5) return mr[u][int'(a)];
        if (int'(a) == 6) return {27'd0, 1'((kk >> (BW - 1)) & 1), 4'((kk >> SW) % nd_of(u))};
        return 32'd0;
    endfunction

    task automatic tick(input logic wr, input logic [4:0] a, input logic [31:0] d);
        logic [23:0] e0, e1;
        @(negedge clk);
        cs = 1'b1; write = wr; read = ~wr; addr = a; wr_data = d;
        @(posedge clk);
        if (reset) begin
            e0 = '1;
            e1 = '1;
        end else begin
            e0 = exp_out(0, k);
            e1 = exp_out(1, k);
            if (wr) model_write(a, d);
            k++;
        end
        #1;
        check("an8",    32'(an8),  32'(e0[15:8]));
        check("sseg8",  32'(ss8),  32'(e0[7:0]));
        check("an12",   32'(an12), 32'(e1[19:8]));
        check("sseg12", 32'(ss12), 32'(e1[7:0]));
        check("rd8",    rd8,       exp_rd(0, a, k));
        check("rd12",   rd12,      exp_rd(1, a, k));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 5'($urandom_range(0, 7)), 32'd0);
    endtask

    initial begin
        int cnt;
        int sel;
        logic [4:0]  wa;
        logic [31:0] wd;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_an8", 32'(an8), 32'hFF);
        check("rst_sseg8", 32'(ss8), 32'hFF);
        tick(1'b1, 5'd0, 32'h1234_5678);   // write during reset must be lost
        tick(1'b0, 5'd5, 32'd0);
        tick(1'b0, 5'd0, 32'd0);
        reset = 1'b0;

        tick(1'b0, 5'd6, 32'd0);
        check("first_an8", 32'(an8), 32'hFE);
        check("first_sseg8", 32'(ss8), 32'hC0);
        idle(3200);

        // Hex digits with decimal point on digit 0.
        tick(1'b1, 5'd0, 32'h0000_00A8);
        tick(1'b1, 5'd2, 32'h0000_0001);
        tick(1'b0, 5'd0, 32'd0);
        check("rd_data_lo", rd8, 32'h0000_00A8);
        tick(1'b0, 5'd2, 32'd0);
        check("rd_dp", rd8, 32'h1);
        for (int i = 0; i < 2048; i++) begin
            tick(1'b0, 5'd6, 32'd0);
            if (an8 == 8'hFE) check("dig0", 32'(ss8), 32'h00);
            if (an8 == 8'hFD) check("dig1", 32'(ss8), 32'h88);
            if (an8 == 8'hFB) check("dig2", 32'(ss8), 32'hC0);
        end

        // Brightness: a quarter duty lights each slot for 64 clocks.
        tick(1'b1, 5'd5, 32'h140);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1'b0, 5'd5, 32'd0);
            if (an8 != 8'hFF) cnt++;
        end
        check("duty40_lit", 32'(cnt), 32'd64);
        tick(1'b1, 5'd5, 32'h100);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1'b0, 5'd6, 32'd0);
            if (an8 != 8'hFF) cnt++;
        end
        check("duty0_lit", 32'(cnt), 32'd0);
        tick(1'b1, 5'd5, 32'h1FF);

        tick(1'b1, 5'd4, 32'h04);
        idle(2200);
        tick(1'b1, 5'd4, 32'h0);

        // Upper digits and mask truncation on the wider display.
        tick(1'b1, 5'd1, 32'h321);
        tick(1'b1, 5'd3, 32'hFFFF);
        tick(1'b0, 5'd3, 32'd0);
        check("blank_rd12", rd12, 32'h0FFF);
        check("blank_rd8", rd8, 32'h00FF);
        tick(1'b1, 5'd3, 32'h0);
        tick(1'b0, 5'd1, 32'd0);
        check("hi_rd8", rd8, 32'h0);
        idle(3300);

        tick(1'b1, 5'd9, 32'hFFFF_FFFF);
        tick(1'b1, 5'd6, 32'hFFFF_FFFF);
        tick(1'b0, 5'd9, 32'd0);

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            wa  = (sel <= 6) ? 5'(sel) : ((sel == 7) ? 5'd9 : 5'd31);
            wd  = $urandom;
            if (wa == 5'd5) begin
                case ($urandom_range(0, 3))
                    0: wd[7:0] = 8'h00;
                    1: wd[7:0] = 8'hFF;
                    default: ;
                endcase
                wd[8] = ($urandom_range(0, 4) != 0);
            end
            tick(1'b1, wa, wd);
            idle($urandom_range(20, 400));
        end

        // Asynchronous reset in the middle of a slot.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_an8", 32'(an8), 32'hFF);
        check("async_sseg8", 32'(ss8), 32'hFF);
        check("async_an12", 32'(an12), 32'hFFF);
        model_reset();
        tick(1'b1, 5'd5, 32'h0);
        tick(1'b0, 5'd5, 32'd0);
        check("rst_ctrl", rd8, 32'h1FF);
        reset = 1'b0;
        idle(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
